// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/pause/step/halt sequencer gating PC_EN and keeping execution counters
module cpu_run_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        GO,
  input  logic        STEP,
  input  logic        SysCALL,
  input  logic        V0_IS_10,
  input  logic        BranchTaken,
  input  logic        JumpAny,
  output logic        PC_EN,
  output logic        HALTED,
  output logic [2:0]  STATE,
  output logic [31:0] INSTR_CNT,
  output logic [15:0] BR_CNT,
  output logic [15:0] J_CNT
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_STEP  = 3'd3,
    S_HALT  = 3'd4
  } state_t;
  state_t state, nxt;
  logic go_q, step_q;
  logic go_rise, step_rise, exit_req, commit;
  assign go_rise   = GO & ~go_q;
  assign step_rise = STEP & ~step_q;
  assign exit_req  = SysCALL & V0_IS_10;
  assign commit    = (state == S_RUN) | (state == S_STEP);
  assign PC_EN     = commit & ~exit_req;
  assign HALTED    = state == S_HALT;
  assign STATE     = state;
  // next state: go beats step, exit halts only while an instruction executes, HALT is sticky
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_PAUSE: nxt = go_rise ? S_RUN : step_rise ? S_STEP : state;
      S_RUN:           nxt = exit_req ? S_HALT : go_rise ? S_PAUSE : S_RUN;
      S_STEP:          nxt = exit_req ? S_HALT : S_PAUSE;
      default:         nxt = S_HALT;
    endcase
  end
  // state, button history (reset high so held buttons do not fire) and counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      go_q      <= 1'b1;
      step_q    <= 1'b1;
      INSTR_CNT <= '0;
      BR_CNT    <= '0;
      J_CNT     <= '0;
    end else begin
      state  <= nxt;
      go_q   <= GO;
      step_q <= STEP;
      if (commit) INSTR_CNT <= INSTR_CNT + 32'd1;
      if (PC_EN && BranchTaken) BR_CNT <= BR_CNT + 16'd1;
      if (PC_EN && JumpAny) J_CNT <= J_CNT + 16'd1;
    end
  end
endmodule
